swap_sched: RTL and testbench
=============================

Name: swap_sched

Overview:
- Shared register bank of DEPTH words, each WIDTH bits, with a single temp-register swap engine.
- Two requesters each ask for a swap of two bank entries. A round-robin arbiter grants one requester at a time.
- A 3-step FSM performs the swap through the temp register: load temp, move, store.
- Sits between requester logic and the variable bank. It is the only block allowed to reorder bank contents.

Parameters:
- WIDTH, 4, data width of each bank entry and of temp.
- DEPTH, 4, number of bank entries.
- IDXW, 2, index width; must equal log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 swap request; held until done0
- ia0  input  IDXW  requester 0 first index
- ib0  input  IDXW  requester 0 second index
- done0  output  1  one-cycle pulse: requester 0 swap complete
- req1  input  1  requester 1 swap request; held until done1
- ia1  input  IDXW  requester 1 first index
- ib1  input  IDXW  requester 1 second index
- done1  output  1  one-cycle pulse: requester 1 swap complete
- wr_en  input  1  external bank write strobe
- wr_idx  input  IDXW  external write index
- wr_data  input  WIDTH  external write data
- rd_idx  input  IDXW  read index
- rd_data  output  WIDTH  combinational bank[rd_idx]
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst=1):
  - bank[k] = k+1, truncated to WIDTH (default 1,2,3,4).
  - temp = 0, state = IDLE, done0 = done1 = 0, busy = 0.
  - Last-served = 1, so requester 0 wins the first tie.
- States: IDLE, LOAD, MOVE, STORE.
- IDLE:
  - Eligible requester: reqN=1 and doneN=0 in that cycle.
  - If none eligible, stay in IDLE.
  - If one eligible, grant it.
  - If both eligible, grant the one that is not last-served.
  - On grant edge: latch sel, ia and ib from the granted requester; last-served <= sel; go to LOAD.
- LOAD: temp <= bank[ia]; go to MOVE.
- MOVE: bank[ia] <= bank[ib]; go to STORE.
- STORE: bank[ib] <= temp; done[sel] <= 1 for exactly one cycle; go to IDLE.
- Latency: 4 edges from the grant edge to done visible. The next grant can occur on the edge that ends the done cycle, i.e. back-to-back every 4 cycles.
- Indices latch at grant; changing iaN/ibN or dropping reqN mid-swap has no effect and does not abort the swap.
- Requesters drop reqN in the done cycle. The arbiter never re-grants a requester in its own done cycle.
- ia == ib: full 4-cycle sequence runs, entry value unchanged, done still pulses.
- wr_en:
  - Honoured only when state = IDLE: bank[wr_idx] <= wr_data.
  - Ignored in LOAD, MOVE and STORE; no queuing.
  - If wr_en and a grant fall in the same IDLE cycle, the write lands first and LOAD sees the written value.
- rd_data reflects register contents, including mid-swap intermediate values (after MOVE, bank[ia] == bank[ib]).
- Reset mid-swap: immediate return to reset values, bank reinitialised, no done pulse. Pending reqs are re-arbitrated from requester 0 priority.
- done0 and done1 are never high together.

Test Plan:
- After reset, req0=1, ia0=0, ib0=1 -> done0 pulses 4 cycles after grant; bank = 2,1,3,4; busy high for 3 cycles.
- req0 and req1 both raised the same cycle (0<->1 and 2<->3) -> requester 0 served first, then requester 1 starts on the edge ending the done0 cycle; final bank = 2,1,4,3; done0 precedes done1 by 4 cycles.
- Both held continuously for 4 swaps (req0: 0<->3, req1: 1<->2) -> grants alternate 0,1,0,1; bank returns to 1,2,3,4.
- req1 with ia1=ib1=2 -> done1 after 4 cycles; bank unchanged 1,2,3,4.
- wr_en in MOVE (wr_idx=3, wr_data=9) -> ignored, bank[3] stays 4. Same write in IDLE -> bank[3] = 9.
- rst asserted during MOVE of a 0<->1 swap -> bank = 1,2,3,4, temp = 0, busy = 0, no done pulse.

Source files
------------

// File: rtl/swap_sched.sv
// swap_sched: round-robin arbitrated swap engine over a shared register bank,
// swapping two entries through a temp register in three steps.
module swap_sched #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int IDXW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [IDXW-1:0]  ia0,
    input  logic [IDXW-1:0]  ib0,
    output logic             done0,
    input  logic             req1,
    input  logic [IDXW-1:0]  ia1,
    input  logic [IDXW-1:0]  ib1,
    output logic             done1,
    input  logic             wr_en,
    input  logic [IDXW-1:0]  wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDXW-1:0]  rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, LOAD, MOVE, STORE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_bank [DEPTH];
    logic [WIDTH-1:0] r_temp;
    logic [IDXW-1:0]  r_ia, r_ib;
    logic             r_sel, r_last, r_done0, r_done1;
    logic             w_e0, w_e1, w_grant, w_gsel;
    // a requester still showing its done pulse is not eligible, so it is never re-granted at once
    always_comb begin
        w_e0    = req0 & ~r_done0;
        w_e1    = req1 & ~r_done1;
        w_grant = (r_state == IDLE) & (w_e0 | w_e1);
        w_gsel  = (w_e0 & w_e1) ? ~r_last : w_e1;
        w_next  = (r_state == IDLE) ? (w_grant ? LOAD : IDLE) :
                  (r_state == LOAD) ? MOVE :
                  (r_state == MOVE) ? STORE : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) r_bank[k] <= WIDTH'(k + 1);
            r_temp  <= '0;
            r_ia    <= '0;
            r_ib    <= '0;
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
        end else begin
            r_done0 <= (r_state == STORE) & ~r_sel;
            r_done1 <= (r_state == STORE) & r_sel;
            if (r_state == IDLE && wr_en) r_bank[wr_idx] <= wr_data;
            if (w_grant) begin
                r_sel  <= w_gsel;
                r_last <= w_gsel;
                r_ia   <= w_gsel ? ia1 : ia0;
                r_ib   <= w_gsel ? ib1 : ib0;
            end
            if (r_state == LOAD) r_temp <= r_bank[r_ia];
            if (r_state == MOVE) r_bank[r_ia] <= r_bank[r_ib];
            if (r_state == STORE) r_bank[r_ib] <= r_temp;
        end
    end
    assign rd_data = r_bank[rd_idx];
    assign busy    = r_state != IDLE;
    assign done0   = r_done0;
    assign done1   = r_done1;
endmodule

// File: tb/tb_swap_sched.sv
// tb_swap_sched: randomized scenarios checked against an array-level bank/arbiter model.
module tb_swap_sched;
    localparam int W = 4, D = 4, I = 2;
    logic         clk = 0, rst = 1, req0 = 0, req1 = 0, wr_en = 0;
    logic [I-1:0] ia0 = 0, ib0 = 0, ia1 = 0, ib1 = 0, wr_idx = 0, rd_idx = 0;
    logic [W-1:0] wr_data = 0;
    logic         done0, done1, busy;
    logic [W-1:0] rd_data;
    int n_run = 0, n_fail = 0;
    int mb[D];
    bit mlast;

    swap_sched #(.WIDTH(W), .DEPTH(D), .IDXW(I)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .ia0(ia0), .ib0(ib0), .done0(done0),
        .req1(req1), .ia1(ia1), .ib1(ib1), .done1(done1),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset;
        for (int k = 0; k < D; k++) mb[k] = (k + 1) % (1 << W);
        mlast = 1;
    endfunction

    function automatic void model_swap(int a, int b);
        int t = mb[a];
        mb[a] = mb[b];
        mb[b] = t;
    endfunction

    // drives one or two requests, dropping each in its done cycle; reports done cycle per requester
    task automatic run_pair(input bit r0, input bit r1, input int a0, input int b0,
                            input int a1, input int b1,
                            output int t0, output int t1, output int busyc, output int clash);
        t0 = -1; t1 = -1; busyc = 0; clash = 0;
        tick;
        ia0 = I'(a0); ib0 = I'(b0); ia1 = I'(a1); ib1 = I'(b1);
        req0 = r0; req1 = r1;
        for (int c = 1; c <= 40 && (req0 || req1); c++) begin
            tick;
            if (busy) busyc++;
            if (done0 && done1) clash++;
            if (done0) begin t0 = c; req0 = 0; end
            if (done1) begin t1 = c; req1 = 0; end
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        tick; tick;
        rst = 0;
        model_reset();
        n_run++;
        if (busy !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done0=%b done1=%b, want 0 0 0", busy, done0, done1);
        end
        for (int k = 0; k < D; k++) begin
            rd_idx = I'(k); #1;
            n_run++;
            if (rd_data !== W'(mb[k])) begin
                n_fail++;
                $display("FAIL reset_bank[%0d]: got %0d want %0d", k, rd_data, mb[k]);
            end
        end
    endtask

    task automatic test_single;
        int lat = -1, busyc = 0;
        tick;
        req0 = 1; ia0 = 0; ib0 = 1;
        for (int c = 1; c <= 20; c++) begin
            tick;
            if (busy) busyc++;
            if (c == 1) begin
                ia0 = I'($urandom); ib0 = I'($urandom); req0 = 0;
            end
            if (done0) begin lat = c; break; end
        end
        req0 = 0;
        model_swap(0, 1); mlast = 0;
        n_run++;
        if (lat != 4) begin n_fail++; $display("FAIL single_latency: got %0d want 4", lat); end
        n_run++;
        if (busyc != 3) begin n_fail++; $display("FAIL single_busy_cycles: got %0d want 3", busyc); end
        tick;
        n_run++;
        if (done0 !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse_width: done0=%b want 0", done0); end
        for (int k = 0; k < D; k++) begin
            rd_idx = I'(k); #1;
            n_run++;
            if (rd_data !== W'(mb[k])) begin
                n_fail++;
                $display("FAIL single_bank[%0d]: got %0d want %0d", k, rd_data, mb[k]);
            end
        end
    endtask

    task automatic test_both;
        int t0, t1, bc, cl, first;
        first = mlast ? 0 : 1;
        run_pair(1, 1, 0, 1, 2, 3, t0, t1, bc, cl);
        if (first == 0) begin model_swap(0, 1); model_swap(2, 3); end
        else begin model_swap(2, 3); model_swap(0, 1); end
        mlast = (first == 0);
        n_run++;
        if (t0 != (first == 0 ? 4 : 8) || t1 != (first == 1 ? 4 : 8)) begin
            n_fail++;
            $display("FAIL both_order: done0@%0d done1@%0d, first=%0d expected", t0, t1, first);
        end
        n_run++;
        if (cl != 0 || bc != 6) begin
            n_fail++;
            $display("FAIL both_clash_busy: clash=%0d busy=%0d want 0 and 6", cl, bc);
        end
        for (int k = 0; k < D; k++) begin
            rd_idx = I'(k); #1;
            n_run++;
            if (rd_data !== W'(mb[k])) begin
                n_fail++;
                $display("FAIL both_bank[%0d]: got %0d want %0d", k, rd_data, mb[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int seq[4], cyc[4];
        int cnt = 0, want;
        tick;
        req0 = 1; ia0 = 0; ib0 = 3;
        req1 = 1; ia1 = 1; ib1 = 2;
        for (int c = 1; c <= 40 && cnt < 4; c++) begin
            tick;
            if (done0) begin seq[cnt] = 0; cyc[cnt] = c; cnt++; end
            if (done1) begin seq[cnt] = 1; cyc[cnt] = c; cnt++; end
        end
        req0 = 0; req1 = 0;
        n_run++;
        if (cnt != 4) begin n_fail++; $display("FAIL b2b_count: got %0d dones want 4", cnt); end
        for (int k = 0; k < 4 && k < cnt; k++) begin
            want = mlast ? 0 : 1;
            if (want == 0) model_swap(0, 3); else model_swap(1, 2);
            mlast = (want == 1);
            n_run++;
            if (seq[k] != want || cyc[k] != 4 * (k + 1)) begin
                n_fail++;
                $display("FAIL b2b_grant[%0d]: req%0d@%0d want req%0d@%0d", k, seq[k], cyc[k], want, 4 * (k + 1));
            end
        end
        for (int k = 0; k < D; k++) begin
            rd_idx = I'(k); #1;
            n_run++;
            if (rd_data !== W'(mb[k])) begin
                n_fail++;
                $display("FAIL b2b_bank[%0d]: got %0d want %0d", k, rd_data, mb[k]);
            end
        end
    endtask

    task automatic test_same_idx;
        int t0, t1, bc, cl;
        run_pair(0, 1, 0, 0, 2, 2, t0, t1, bc, cl);
        mlast = 1;
        n_run++;
        if (t1 != 4 || t0 != -1) begin
            n_fail++;
            $display("FAIL same_idx_done: done1@%0d done0@%0d want 4 and none", t1, t0);
        end
        for (int k = 0; k < D; k++) begin
            rd_idx = I'(k); #1;
            n_run++;
            if (rd_data !== W'(mb[k])) begin
                n_fail++;
                $display("FAIL same_idx_bank[%0d]: got %0d want %0d", k, rd_data, mb[k]);
            end
        end
    endtask

    task automatic test_write;
        int x, y, d, lat = -1;
        tick;
        req0 = 1; ia0 = 0; ib0 = 1;
        tick; tick;
        wr_en = 1; wr_idx = 3; wr_data = 9;
        tick;
        wr_en = 0;
        rd_idx = 0; #1;
        n_run++;
        if (rd_data !== W'(mb[1])) begin n_fail++; $display("FAIL mid_swap_ia: got %0d want %0d", rd_data, mb[1]); end
        rd_idx = 1; #1;
        n_run++;
        if (rd_data !== W'(mb[1])) begin n_fail++; $display("FAIL mid_swap_ib: got %0d want %0d", rd_data, mb[1]); end
        tick;
        n_run++;
        if (done0 !== 1'b1) begin n_fail++; $display("FAIL write_swap_done: done0=%b want 1", done0); end
        req0 = 0;
        model_swap(0, 1); mlast = 0;
        rd_idx = 3; #1;
        n_run++;
        if (rd_data !== W'(mb[3])) begin n_fail++; $display("FAIL busy_write_ignored: got %0d want %0d", rd_data, mb[3]); end
        tick;
        wr_en = 1; wr_idx = 3; wr_data = 9;
        tick;
        wr_en = 0; mb[3] = 9;
        #1;
        n_run++;
        if (rd_data !== 4'd9) begin n_fail++; $display("FAIL idle_write: got %0d want 9", rd_data); end
        x = $urandom_range(0, D - 1);
        y = (x + $urandom_range(1, D - 1)) % D;
        d = $urandom_range(0, (1 << W) - 1);
        req1 = 1; ia1 = I'(x); ib1 = I'(y);
        wr_en = 1; wr_idx = I'(x); wr_data = W'(d);
        tick;
        wr_en = 0;
        mb[x] = d;
        for (int c = 2; c <= 20; c++) begin
            tick;
            if (done1) begin lat = c; break; end
        end
        req1 = 0;
        model_swap(x, y); mlast = 1;
        n_run++;
        if (lat != 4) begin n_fail++; $display("FAIL write_grant_latency: got %0d want 4", lat); end
        for (int k = 0; k < D; k++) begin
            rd_idx = I'(k); #1;
            n_run++;
            if (rd_data !== W'(mb[k])) begin
                n_fail++;
                $display("FAIL write_grant_bank[%0d]: got %0d want %0d", k, rd_data, mb[k]);
            end
        end
    endtask

    task automatic test_rst_mid;
        int t0, t1, bc, cl, sawdone = 0;
        tick;
        req0 = 1; ia0 = 0; ib0 = 1;
        tick; tick;
        rst = 1; #1;
        model_reset();
        n_run++;
        if (busy !== 1'b0 || done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: busy=%b done0=%b want 0 0", busy, done0);
        end
        for (int k = 0; k < D; k++) begin
            rd_idx = I'(k); #1;
            n_run++;
            if (rd_data !== W'(mb[k])) begin
                n_fail++;
                $display("FAIL rst_mid_bank[%0d]: got %0d want %0d", k, rd_data, mb[k]);
            end
        end
        req1 = 1;
        for (int c = 0; c < 4; c++) begin
            tick;
            if (done0 || done1) sawdone++;
        end
        req0 = 0; req1 = 0;
        rst = 0;
        n_run++;
        if (sawdone != 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", sawdone); end
        run_pair(1, 1, 2, 3, 1, 2, t0, t1, bc, cl);
        model_swap(2, 3); model_swap(1, 2); mlast = 1;
        n_run++;
        if (t0 != 4 || t1 != 8) begin
            n_fail++;
            $display("FAIL rst_rearbitrate: done0@%0d done1@%0d want 4 and 8", t0, t1);
        end
        for (int k = 0; k < D; k++) begin
            rd_idx = I'(k); #1;
            n_run++;
            if (rd_data !== W'(mb[k])) begin
                n_fail++;
                $display("FAIL rst_rearb_bank[%0d]: got %0d want %0d", k, rd_data, mb[k]);
            end
        end
    endtask

    task automatic test_random;
        int a0, b0, a1, b1, t0, t1, bc, cl, first, wi, wd;
        bit r0, r1;
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                wi = $urandom_range(0, D - 1);
                wd = $urandom_range(0, (1 << W) - 1);
                wr_en = 1; wr_idx = I'(wi); wr_data = W'(wd);
                tick;
                wr_en = 0; mb[wi] = wd;
            end
            r0 = 1'($urandom); r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1;
            a0 = $urandom_range(0, D - 1); b0 = $urandom_range(0, D - 1);
            a1 = $urandom_range(0, D - 1); b1 = $urandom_range(0, D - 1);
            first = (r0 && r1) ? (mlast ? 0 : 1) : (r1 ? 1 : 0);
            run_pair(r0, r1, a0, b0, a1, b1, t0, t1, bc, cl);
            if (first == 0) begin
                model_swap(a0, b0);
                if (r1) model_swap(a1, b1);
            end else begin
                model_swap(a1, b1);
                if (r0) model_swap(a0, b0);
            end
            mlast = (r0 && r1) ? (first == 0) : (first == 1);
            n_run++;
            if (t0 != (!r0 ? -1 : (first == 0 ? 4 : 8)) || t1 != (!r1 ? -1 : (first == 1 ? 4 : 8)) || cl != 0) begin
                n_fail++;
                $display("FAIL random_timing[%0d]: done0@%0d done1@%0d clash=%0d req=%b%b first=%0d",
                         it, t0, t1, cl, r0, r1, first);
            end
            for (int k = 0; k < D; k++) begin
                rd_idx = I'(k); #1;
                n_run++;
                if (rd_data !== W'(mb[k])) begin
                    n_fail++;
                    $display("FAIL random_bank[%0d][%0d]: got %0d want %0d", it, k, rd_data, mb[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_reset();
        test_back_to_back();
        test_same_idx();
        test_write();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
